// File: rtl/operand_assembler.sv
// Pops FIFO words and assembles them into an operand pair (A then B) for the
// modular multiplier. The pair is offered over valid/ready and held until it is taken.
module operand_assembler #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 256,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    fifo_rd_data,
    input  logic                fifo_empty,
    output logic                fifo_rd,
    output logic [OP_WIDTH-1:0] op_a,
    output logic [OP_WIDTH-1:0] op_b,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [CNT_W-1:0]    pair_cnt
);

    localparam int WORDS = OP_WIDTH / WIDTH;
    localparam int TOTAL = 2 * WORDS;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam logic [IDX_W-1:0] TOTAL_C = IDX_W'(TOTAL);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(TOTAL - 1);

    typedef enum logic {
        LOAD,
        PRESENT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        issue_cnt;
    logic [IDX_W-1:0]        recv_cnt;
    logic                    rd_pending;
    logic [2*OP_WIDTH-1:0]   shift_buf;
    logic                    capture;
    logic                    accept;

    // Reads are also gated by rst so nothing is popped while the FIFO is being reset.
    always_comb begin
        state_next = state;
        fifo_rd    = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                fifo_rd = !rst && !fifo_empty && (issue_cnt < TOTAL_C);
                capture = rd_pending;
                if (capture && (recv_cnt == LAST_C))
                    state_next = PRESENT;
            end
            PRESENT: begin
                accept = op_ready;
                if (op_ready)
                    state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            rd_pending <= 1'b0;
            shift_buf  <= '0;
            pair_cnt   <= '0;
        end else begin
            state      <= state_next;
            rd_pending <= fifo_rd;
            if (fifo_rd)
                issue_cnt <= issue_cnt + IDX_W'(1);
            // New words enter at the top so the first word ends up as the LSW of A.
            if (capture) begin
                shift_buf <= {fifo_rd_data, shift_buf[2*OP_WIDTH-1:WIDTH]};
                recv_cnt  <= recv_cnt + IDX_W'(1);
            end
            if (accept) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
                pair_cnt  <= pair_cnt + CNT_W'(1);
            end
        end
    end

    assign op_valid = (state == PRESENT);
    assign op_a     = shift_buf[OP_WIDTH-1:0];
    assign op_b     = shift_buf[2*OP_WIDTH-1:OP_WIDTH];

endmodule
